// File: rtl/mem_stage_lsu_pkg.sv
// Shared widths, encodings and pending-request record for the memory stage.
package mem_stage_lsu_pkg;

    localparam int DBITS     = 32;
    localparam int REGNOBITS = 5;
    localparam int IOPBITS   = 6;
    localparam int TIMEOUT   = 255;
    localparam int CNT_W     = $clog2(TIMEOUT + 1);

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'd0,
        EXC_MISALIGN = 2'd1,
        EXC_TIMEOUT  = 2'd2
    } exc_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    // Everything about an accepted instruction that must survive until write-back.
    typedef struct packed {
        logic [DBITS-1:0]     pc;
        logic [31:0]          inst;
        logic [IOPBITS-1:0]   op;
        logic [DBITS-1:0]     inst_count;
        logic [DBITS-1:0]     aluout;
        logic [REGNOBITS-1:0] rd;
        logic                 wr_reg;
        logic                 is_load;
        logic [1:0]           size;
        logic                 is_unsigned;
    } pend_t;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// AGEX-side, data-memory and write-back/forwarding signals of the memory stage.
interface mem_stage_lsu_if;
    import mem_stage_lsu_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [DBITS-1:0]     in_pc;
    logic [31:0]          in_inst;
    logic [IOPBITS-1:0]   in_op;
    logic [DBITS-1:0]     in_inst_count;
    logic [DBITS-1:0]     in_aluout;
    logic [DBITS-1:0]     in_store_data;
    logic [REGNOBITS-1:0] in_rd;
    logic                 in_wr_reg;
    logic                 in_mem_rd;
    logic                 in_mem_wr;
    logic [1:0]           in_size;
    logic                 in_unsigned;
    logic                 dmem_req;
    logic                 dmem_we;
    logic [DBITS-1:0]     dmem_addr;
    logic [DBITS-1:0]     dmem_wdata;
    logic [3:0]           dmem_wstrb;
    logic                 dmem_ack;
    logic [DBITS-1:0]     dmem_rdata;
    logic                 wb_valid;
    logic [DBITS-1:0]     wb_pc;
    logic [31:0]          wb_inst;
    logic [IOPBITS-1:0]   wb_op;
    logic [DBITS-1:0]     wb_inst_count;
    logic [DBITS-1:0]     wb_result;
    logic [REGNOBITS-1:0] wb_rd;
    logic                 wb_wr_reg;
    logic [1:0]           wb_exc;
    logic                 fwd_valid;
    logic                 fwd_busy;
    logic [REGNOBITS-1:0] fwd_rd;
    logic [DBITS-1:0]     fwd_value;

    modport slave (
        input  in_valid, in_pc, in_inst, in_op, in_inst_count, in_aluout, in_store_data,
               in_rd, in_wr_reg, in_mem_rd, in_mem_wr, in_size, in_unsigned,
               dmem_ack, dmem_rdata,
        output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
               wb_valid, wb_pc, wb_inst, wb_op, wb_inst_count, wb_result, wb_rd,
               wb_wr_reg, wb_exc, fwd_valid, fwd_busy, fwd_rd, fwd_value
    );

    modport master (
        output in_valid, in_pc, in_inst, in_op, in_inst_count, in_aluout, in_store_data,
               in_rd, in_wr_reg, in_mem_rd, in_mem_wr, in_size, in_unsigned,
               dmem_ack, dmem_rdata,
        input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
               wb_valid, wb_pc, wb_inst, wb_op, wb_inst_count, wb_result, wb_rd,
               wb_wr_reg, wb_exc, fwd_valid, fwd_busy, fwd_rd, fwd_value
    );

endinterface

// File: rtl/mem_stage_lsu_lane_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
module lsu_lane_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [1:0]       addr_lo_i,
    input  logic [1:0]       size_i,
    input  logic             unsigned_i,
    input  logic [DBITS-1:0] store_data_i,
    input  logic [DBITS-1:0] rdata_i,
    output logic [DBITS-1:0] wdata_o,
    output logic [3:0]       wstrb_o,
    output logic             misaligned_o,
    output logic [DBITS-1:0] load_value_o
);

    logic [DBITS-1:0] lane_s;

    // Size 3 falls into the word branch.
    always_comb begin
        lane_s       = rdata_i >> {addr_lo_i, 3'b000};
        wdata_o      = store_data_i;
        wstrb_o      = 4'b1111;
        misaligned_o = 1'b0;
        load_value_o = rdata_i;
        case (size_i)
            SZ_B: begin
                wstrb_o      = 4'b0001 << addr_lo_i;
                wdata_o      = {4{store_data_i[7:0]}};
                load_value_o = {{(DBITS-8){lane_s[7] & ~unsigned_i}}, lane_s[7:0]};
            end
            SZ_H: begin
                misaligned_o = addr_lo_i[0];
                wstrb_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o      = {2{store_data_i[15:0]}};
                load_value_o = {{(DBITS-16){lane_s[15] & ~unsigned_i}}, lane_s[15:0]};
            end
            default: begin
                misaligned_o = (addr_lo_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory stage: accepts AGEX instructions, runs dmem loads/stores, fills the WB latch.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    mem_stage_lsu_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e               state_q, state_d;
    pend_t                pend_q, pend_d, in_s, src_s;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 req_q, req_d, we_q, we_d;
    logic [DBITS-1:0]     addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic                 wb_valid_q, wb_valid_d, wb_wr_reg_q, wb_wr_reg_d;
    logic [DBITS-1:0]     wb_pc_q, wb_pc_d, wb_cnt_q, wb_cnt_d, wb_result_q, wb_result_d;
    logic [31:0]          wb_inst_q, wb_inst_d;
    logic [IOPBITS-1:0]   wb_op_q, wb_op_d;
    logic [REGNOBITS-1:0] wb_rd_q, wb_rd_d, fwd_rd_q, fwd_rd_d;
    logic [1:0]           wb_exc_q, wb_exc_d;
    logic                 fwd_valid_q, fwd_valid_d, fwd_busy_q, fwd_busy_d;
    logic [DBITS-1:0]     fwd_value_q, fwd_value_d;
    logic [1:0]           al_addr_s, al_size_s;
    logic                 al_uns_s, al_mis_s;
    logic [DBITS-1:0]     al_wdata_s, al_load_s;
    logic [3:0]           al_wstrb_s;

    // In IDLE the aligner sees the incoming op; in ACCESS it decodes the pending load.
    assign al_addr_s = (state_q == ST_ACCESS) ? pend_q.aluout[1:0] : bus.in_aluout[1:0];
    assign al_size_s = (state_q == ST_ACCESS) ? pend_q.size        : bus.in_size;
    assign al_uns_s  = (state_q == ST_ACCESS) ? pend_q.is_unsigned : bus.in_unsigned;

    lsu_lane_align u_align (
        .addr_lo_i    (al_addr_s),
        .size_i       (al_size_s),
        .unsigned_i   (al_uns_s),
        .store_data_i (bus.in_store_data),
        .rdata_i      (bus.dmem_rdata),
        .wdata_o      (al_wdata_s),
        .wstrb_o      (al_wstrb_s),
        .misaligned_o (al_mis_s),
        .load_value_o (al_load_s)
    );

    // Next-state, dmem request and MEM-latch computation.
    always_comb begin
        in_s             = '0;
        in_s.pc          = bus.in_pc;
        in_s.inst        = bus.in_inst;
        in_s.op          = bus.in_op;
        in_s.inst_count  = bus.in_inst_count;
        in_s.aluout      = bus.in_aluout;
        in_s.rd          = bus.in_rd;
        in_s.wr_reg      = bus.in_wr_reg & (bus.in_rd != {REGNOBITS{1'b0}});
        in_s.is_load     = bus.in_mem_rd & ~bus.in_mem_wr;
        in_s.size        = bus.in_size;
        in_s.is_unsigned = bus.in_unsigned;

        state_d     = state_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        wb_valid_d  = 1'b0;
        wb_wr_reg_d = 1'b0;
        wb_exc_d    = EXC_NONE;
        wb_result_d = wb_result_q;
        src_s       = (state_q == ST_ACCESS) ? pend_q : in_s;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    pend_d = in_s;
                    if (!(bus.in_mem_rd || bus.in_mem_wr)) begin
                        wb_valid_d  = 1'b1;
                        wb_result_d = bus.in_aluout;
                        wb_wr_reg_d = in_s.wr_reg;
                    end else if (al_mis_s) begin
                        wb_valid_d  = 1'b1;
                        wb_result_d = bus.in_aluout;
                        wb_exc_d    = EXC_MISALIGN;
                    end else begin
                        state_d = ST_ACCESS;
                        cnt_d   = {CNT_W{1'b0}};
                        req_d   = 1'b1;
                        we_d    = bus.in_mem_wr;
                        addr_d  = {bus.in_aluout[DBITS-1:2], 2'b00};
                        wdata_d = al_wdata_s;
                        wstrb_d = bus.in_mem_wr ? al_wstrb_s : 4'b0000;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // An ack on the final wait cycle still completes normally.
                if (bus.dmem_ack) begin
                    state_d     = ST_IDLE;
                    req_d       = 1'b0;
                    we_d        = 1'b0;
                    wb_valid_d  = 1'b1;
                    wb_result_d = pend_q.is_load ? al_load_s : pend_q.aluout;
                    wb_wr_reg_d = pend_q.is_load & pend_q.wr_reg;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_IDLE;
                    req_d       = 1'b0;
                    we_d        = 1'b0;
                    cnt_d       = {CNT_W{1'b0}};
                    wb_valid_d  = 1'b1;
                    wb_result_d = pend_q.aluout;
                    wb_exc_d    = EXC_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase

        if (wb_valid_d) begin
            wb_pc_d   = src_s.pc;
            wb_inst_d = src_s.inst;
            wb_op_d   = src_s.op;
            wb_cnt_d  = src_s.inst_count;
            wb_rd_d   = src_s.rd;
        end else begin
            wb_pc_d   = wb_pc_q;
            wb_inst_d = wb_inst_q;
            wb_op_d   = wb_op_q;
            wb_cnt_d  = wb_cnt_q;
            wb_rd_d   = wb_rd_q;
        end

        // A load in flight advertises its rd with a zero value so DE stalls on it.
        fwd_busy_d  = (state_d == ST_ACCESS) & pend_d.is_load;
        fwd_valid_d = (wb_valid_d & wb_wr_reg_d) | fwd_busy_d;
        fwd_rd_d    = fwd_busy_d ? pend_d.rd : wb_rd_d;
        fwd_value_d = fwd_busy_d ? {DBITS{1'b0}} : wb_result_d;
    end

    // State, request and MEM-latch registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            cnt_q       <= {CNT_W{1'b0}};
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= {DBITS{1'b0}};
            wdata_q     <= {DBITS{1'b0}};
            wstrb_q     <= 4'b0000;
            wb_valid_q  <= 1'b0;
            wb_wr_reg_q <= 1'b0;
            wb_exc_q    <= EXC_NONE;
            wb_result_q <= {DBITS{1'b0}};
            wb_pc_q     <= {DBITS{1'b0}};
            wb_inst_q   <= 32'h0000_0000;
            wb_op_q     <= {IOPBITS{1'b0}};
            wb_cnt_q    <= {DBITS{1'b0}};
            wb_rd_q     <= {REGNOBITS{1'b0}};
            fwd_valid_q <= 1'b0;
            fwd_busy_q  <= 1'b0;
            fwd_rd_q    <= {REGNOBITS{1'b0}};
            fwd_value_q <= {DBITS{1'b0}};
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wb_valid_q  <= wb_valid_d;
            wb_wr_reg_q <= wb_wr_reg_d;
            wb_exc_q    <= wb_exc_d;
            wb_result_q <= wb_result_d;
            wb_pc_q     <= wb_pc_d;
            wb_inst_q   <= wb_inst_d;
            wb_op_q     <= wb_op_d;
            wb_cnt_q    <= wb_cnt_d;
            wb_rd_q     <= wb_rd_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_busy_q  <= fwd_busy_d;
            fwd_rd_q    <= fwd_rd_d;
            fwd_value_q <= fwd_value_d;
        end
    end

    assign bus.in_ready      = (state_q == ST_IDLE);
    assign bus.dmem_req      = req_q;
    assign bus.dmem_we       = we_q;
    assign bus.dmem_addr     = addr_q;
    assign bus.dmem_wdata    = wdata_q;
    assign bus.dmem_wstrb    = wstrb_q;
    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_pc         = wb_pc_q;
    assign bus.wb_inst       = wb_inst_q;
    assign bus.wb_op         = wb_op_q;
    assign bus.wb_inst_count = wb_cnt_q;
    assign bus.wb_result     = wb_result_q;
    assign bus.wb_rd         = wb_rd_q;
    assign bus.wb_wr_reg     = wb_wr_reg_q;
    assign bus.wb_exc        = wb_exc_q;
    assign bus.fwd_valid     = fwd_valid_q;
    assign bus.fwd_busy      = fwd_busy_q;
    assign bus.fwd_rd        = fwd_rd_q;
    assign bus.fwd_value     = fwd_value_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed scoreboard bench for mem_stage_lsu.
module tb_mem_stage_lsu;

    typedef struct {
        logic [31:0] result;
        logic        chk_res;
        logic [4:0]  rd;
        logic        wr;
        logic [1:0]  exc;
        logic [31:0] pc;
    } exp_t;

    logic        clk;
    logic        reset;
    int          total;
    int          passed;
    logic [31:0] pc_r;
    exp_t        exp_q[$];

    mem_stage_lsu_if bus();

    mem_stage_lsu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] res, input logic cr, input logic [4:0] rd,
                                input logic wr, input logic [1:0] exc);
        exp_t e;
        e.result = res; e.chk_res = cr; e.rd = rd; e.wr = wr; e.exc = exc; e.pc = 32'h0;
        return e;
    endfunction

    task automatic issue(input exp_t e, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] rd, input logic wr, input logic ld, input logic st,
                         input logic [1:0] sz, input logic uns);
        e.pc = pc_r;
        exp_q.push_back(e);
        bus.in_pc = pc_r;          bus.in_inst = ~pc_r;      bus.in_op = pc_r[7:2];
        bus.in_inst_count = pc_r >> 2;
        bus.in_aluout = addr;      bus.in_store_data = sd;   bus.in_rd = rd;
        bus.in_wr_reg = wr;        bus.in_mem_rd = ld;       bus.in_mem_wr = st;
        bus.in_size = sz;          bus.in_unsigned = uns;    bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.in_mem_rd = 1'b0; bus.in_mem_wr = 1'b0;
        pc_r = pc_r + 32'd4;
    endtask

    task automatic wait_wb(input string tag, input int budget, output int n);
        exp_t e;
        n = 0;
        while (bus.wb_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, " wb_valid"}, {31'b0, bus.wb_valid}, 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, " wb_rd"}, {27'b0, bus.wb_rd}, {27'b0, e.rd});
            chk({tag, " wb_wr_reg"}, {31'b0, bus.wb_wr_reg}, {31'b0, e.wr});
            chk({tag, " wb_exc"}, {30'b0, bus.wb_exc}, {30'b0, e.exc});
            chk({tag, " wb_pc"}, bus.wb_pc, e.pc);
            if (e.chk_res) chk({tag, " wb_result"}, bus.wb_result, e.result);
            else chk({tag, " wb_inst"}, bus.wb_inst, ~e.pc);
        end else begin
            chk({tag, " scoreboard_empty"}, exp_q.size(), 32'd1);
        end
    endtask

    task automatic mem_op(input string tag, input logic [31:0] addr, input logic [31:0] sd,
                          input logic [31:0] rdata, input logic [4:0] rd, input logic ld,
                          input logic st, input logic [1:0] sz, input logic uns, input int waits,
                          input logic [31:0] exp_res, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata);
        logic        is_ld;
        logic [31:0] a_al;
        int          req_n;
        int          n;
        is_ld = ld & ~st;
        a_al  = {addr[31:2], 2'b00};
        issue(mk(exp_res, is_ld, rd, is_ld & (rd != 5'd0), 2'd0), addr, sd, rd, 1'b1, ld, st, sz, uns);
        chk({tag, " in_ready"}, {31'b0, bus.in_ready}, 32'd0);
        chk({tag, " dmem_we"}, {31'b0, bus.dmem_we}, {31'b0, st});
        chk({tag, " fwd_busy"}, {31'b0, bus.fwd_busy}, {31'b0, is_ld});
        if (st) begin
            chk({tag, " wstrb"}, {28'b0, bus.dmem_wstrb}, {28'b0, exp_strb});
            chk({tag, " wdata"}, bus.dmem_wdata, exp_wdata);
        end
        req_n = 0;
        for (int i = 0; i <= waits; i++) begin
            if (bus.dmem_req === 1'b1 && bus.dmem_addr === a_al && bus.in_ready === 1'b0) req_n++;
            if (i == waits) begin
                bus.dmem_ack = 1'b1;
                bus.dmem_rdata = rdata;
            end
            tick();
        end
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = 32'h0;
        chk({tag, " req_cycles"}, req_n, waits + 1);
        wait_wb(tag, 4, n);
        chk({tag, " latency"}, n, 32'd0);
        chk({tag, " req_dropped"}, {31'b0, bus.dmem_req}, 32'd0);
        if (is_ld && rd != 5'd0) chk({tag, " fwd_value"}, bus.fwd_value, exp_res);
    endtask

    initial begin
        int n;
        int req_n;
        int spur;
        total = 0; passed = 0; pc_r = 32'h0000_1000;
        reset = 1'b0;
        bus.in_valid = 1'b0; bus.in_pc = 32'h0; bus.in_inst = 32'h0; bus.in_op = 6'h0;
        bus.in_inst_count = 32'h0; bus.in_aluout = 32'h0; bus.in_store_data = 32'h0;
        bus.in_rd = 5'd0; bus.in_wr_reg = 1'b0; bus.in_mem_rd = 1'b0; bus.in_mem_wr = 1'b0;
        bus.in_size = 2'd0; bus.in_unsigned = 1'b0; bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
        tick(); tick();
        chk("rst wb_valid", {31'b0, bus.wb_valid}, 32'd0);
        chk("rst dmem_req", {31'b0, bus.dmem_req}, 32'd0);
        chk("rst fwd_valid", {31'b0, bus.fwd_valid}, 32'd0);
        chk("rst wb_exc", {30'b0, bus.wb_exc}, 32'd0);
        chk("rst in_ready", {31'b0, bus.in_ready}, 32'd1);
        reset = 1'b1;
        tick();

        // ALU op, then a bubble
        issue(mk(32'h1234, 1'b1, 5'd5, 1'b1, 2'd0), 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        wait_wb("alu", 4, n);
        chk("alu latency", n, 32'd0);
        chk("alu fwd_valid", {31'b0, bus.fwd_valid}, 32'd1);
        chk("alu fwd_rd", {27'b0, bus.fwd_rd}, 32'd5);
        chk("alu fwd_value", bus.fwd_value, 32'h1234);
        tick();
        chk("bubble wb_valid", {31'b0, bus.wb_valid}, 32'd0);

        // ALU op to x0: write suppressed
        issue(mk(32'h55, 1'b1, 5'd0, 1'b0, 2'd0), 32'h55, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        wait_wb("alu_x0", 4, n);
        chk("alu_x0 fwd_valid", {31'b0, bus.fwd_valid}, 32'd0);

        mem_op("lb",   32'h103, 32'h0, 32'h80FF_FF7F, 5'd3, 1'b1, 1'b0, 2'd0, 1'b0, 0, 32'hFFFF_FF80, 4'h0, 32'h0);
        mem_op("lbu",  32'h101, 32'h0, 32'h0000_A500, 5'd4, 1'b1, 1'b0, 2'd0, 1'b1, 1, 32'h0000_00A5, 4'h0, 32'h0);
        mem_op("lh",   32'h102, 32'h0, 32'h8001_1234, 5'd6, 1'b1, 1'b0, 2'd1, 1'b0, 0, 32'hFFFF_8001, 4'h0, 32'h0);
        mem_op("lhu",  32'h102, 32'h0, 32'h8001_1234, 5'd6, 1'b1, 1'b0, 2'd1, 1'b1, 2, 32'h0000_8001, 4'h0, 32'h0);
        mem_op("lw",   32'h104, 32'h0, 32'hDEAD_BEEF, 5'd8, 1'b1, 1'b0, 2'd2, 1'b0, 0, 32'hDEAD_BEEF, 4'h0, 32'h0);
        mem_op("lw_sz3", 32'h700, 32'h0, 32'h1357_9BDF, 5'd9, 1'b1, 1'b0, 2'd3, 1'b0, 0, 32'h1357_9BDF, 4'h0, 32'h0);
        mem_op("sh",   32'h202, 32'hAAAA_BEEF, 32'h0, 5'd9, 1'b0, 1'b1, 2'd1, 1'b0, 3, 32'h0, 4'b1100, 32'hBEEF_BEEF);
        mem_op("sb",   32'h401, 32'h1234_5678, 32'h0, 5'd9, 1'b0, 1'b1, 2'd0, 1'b0, 0, 32'h0, 4'b0010, 32'h7878_7878);
        mem_op("sw_rdwr", 32'h500, 32'hCAFE_F00D, 32'h0, 5'd9, 1'b1, 1'b1, 2'd2, 1'b0, 1, 32'h0, 4'b1111, 32'hCAFE_F00D);
        mem_op("lw_ack_last", 32'h800, 32'h0, 32'h0BAD_F00D, 5'd10, 1'b1, 1'b0, 2'd2, 1'b0, 254, 32'h0BAD_F00D, 4'h0, 32'h0);

        // Misaligned word and half
        issue(mk(32'h0, 1'b0, 5'd7, 1'b0, 2'd1), 32'h301, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
        chk("mis_w dmem_req", {31'b0, bus.dmem_req}, 32'd0);
        wait_wb("mis_w", 4, n);
        chk("mis_w latency", n, 32'd0);
        issue(mk(32'h0, 1'b0, 5'd7, 1'b0, 2'd1), 32'h103, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
        chk("mis_h dmem_req", {31'b0, bus.dmem_req}, 32'd0);
        wait_wb("mis_h", 4, n);

        // Never-acked load times out
        issue(mk(32'h0, 1'b0, 5'd11, 1'b0, 2'd2), 32'h600, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
        req_n = 0; n = 0;
        while (bus.wb_valid !== 1'b1 && n < 400) begin
            if (bus.dmem_req === 1'b1) req_n++;
            tick();
            n++;
        end
        chk("timeout req_cycles", req_n, 32'd255);
        wait_wb("timeout", 1, n);
        chk("timeout req_dropped", {31'b0, bus.dmem_req}, 32'd0);
        chk("timeout in_ready", {31'b0, bus.in_ready}, 32'd1);
        issue(mk(32'h77, 1'b1, 5'd12, 1'b1, 2'd0), 32'h77, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        wait_wb("post_timeout", 4, n);

        // Reset during ACCESS, then a stale ack
        issue(mk(32'h0, 1'b0, 5'd13, 1'b1, 2'd0), 32'h900, 32'h0, 5'd13, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
        chk("rst_mid dmem_req_before", {31'b0, bus.dmem_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid dmem_req_async", {31'b0, bus.dmem_req}, 32'd0);
        chk("rst_mid fwd_valid", {31'b0, bus.fwd_valid}, 32'd0);
        exp_q.delete();
        tick();
        reset = 1'b1;
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'hFFFF_FFFF;
        spur = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 1) bus.dmem_ack = 1'b0;
            if (bus.wb_valid !== 1'b0 || bus.dmem_req !== 1'b0 || bus.fwd_valid !== 1'b0) spur++;
        end
        chk("rst_mid spurious", spur, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory stage between AGEX and WB.
- Accepts one instruction per cycle from AGEX over a valid/ready handshake and performs byte, halfword and word loads and stores against a data memory with a req/ack handshake.
- Registers the result into the MEM latch consumed by WB.
- Stalls AGEX while a memory access is outstanding, and provides a forwarding tap to DE.

Parameters:
DBITS, 32, data/address width
REGNOBITS, 5, register index width
IOPBITS, 6, op-code field width carried to WB
TIMEOUT, 255, max cycles waiting for dmem_ack before error

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  AGEX holds a valid instruction
in_ready  out  1  stage can accept this cycle
in_pc  in  DBITS  instruction PC
in_inst  in  32  instruction word
in_op  in  IOPBITS  op code
in_inst_count  in  DBITS  retire counter tag
in_aluout  in  DBITS  ALU result / effective address
in_store_data  in  DBITS  store data (rs2)
in_rd  in  REGNOBITS  destination register
in_wr_reg  in  1  instruction writes a register
in_mem_rd  in  1  load
in_mem_wr  in  1  store
in_size  in  2  0=byte 1=half 2=word (3 illegal, treated as word)
in_unsigned  in  1  zero-extend load
dmem_req  out  1  memory request
dmem_we  out  1  write enable
dmem_addr  out  DBITS  word-aligned address (addr[1:0]=0)
dmem_wdata  out  DBITS  lane-shifted store data
dmem_wstrb  out  4  byte strobes
dmem_ack  in  1  request done; rdata valid on loads
dmem_rdata  in  DBITS  read word
wb_valid  out  1  MEM latch valid
wb_pc, wb_inst, wb_op, wb_inst_count  out  DBITS/32/IOPBITS/DBITS  pass-through
wb_result  out  DBITS  value to write back
wb_rd  out  REGNOBITS  destination
wb_wr_reg  out  1  register write enable
wb_exc  out  2  0 none, 1 misaligned, 2 bus timeout
fwd_valid, fwd_rd, fwd_value  out  1/REGNOBITS/DBITS  in-flight result tap for DE

Behaviour:
- Reset (reset=0, async): state IDLE; wb_valid, wb_wr_reg, dmem_req, dmem_we, fwd_valid=0; wb_exc=0; timeout counter=0. Other outputs are don't-care but must not be X.
- Pass-through fields are captured into the MEM latch on the same edge as wb_valid.
- States: IDLE, ACCESS.
- IDLE: in_ready=1. Handshake fires on in_valid & in_ready.
  - Non-memory op: next edge wb_valid=1, wb_result=in_aluout, wb_wr_reg=in_wr_reg. Latency 1.
  - Memory op, aligned: latch request fields and go to ACCESS.
  - Memory op, misaligned (half with addr[0]=1, word with addr[1:0]!=0): no dmem access; next edge wb_valid=1, wb_wr_reg=0, wb_exc=1.
  - No handshake: next edge wb_valid=0 (bubble).
- ACCESS: in_ready=0, wb_valid=0.
  - dmem_req=1 and dmem_addr/we/wdata/wstrb stay stable until an ack edge. The first request cycle is the cycle after acceptance.
  - On dmem_ack=1: next edge return to IDLE, wb_valid=1.
    - Load: wb_result = selected lane, sign- or zero-extended; wb_wr_reg=in_wr_reg.
    - Store: wb_wr_reg=0.
  - Minimum load/store latency is 2 cycles (ack in first request cycle).
- Store lanes:
  - Byte: wstrb = 1<<addr[1:0]; wdata = store byte replicated to all lanes.
  - Half: wstrb = 0011 or 1100; wdata = store half replicated to both lanes.
  - Word: wstrb = 1111.
- Timeout: the counter increments each ACCESS cycle without ack. When count reaches TIMEOUT with no ack: drop dmem_req, return to IDLE, wb_valid=1, wb_wr_reg=0, wb_exc=2. An ack arriving on the timeout cycle wins (normal completion).
- Forwarding tap:
  - fwd_valid=1 only while wb_valid & wb_wr_reg; carries wb_rd/wb_result.
  - fwd_valid is also 1 in ACCESS for a load, with fwd_value=0, so DE knows to stall.
  - A DE stall on a load in ACCESS is signalled as a separate qualifier: fwd_busy=fwd_valid in ACCESS.
- rd=0: wb_wr_reg is forced to 0.
- in_mem_rd & in_mem_wr both 1: treated as store.
- Reset mid-ACCESS: dmem_req drops asynchronously and the outstanding transaction is abandoned; a late ack after reset is ignored in IDLE.
- dmem_ack in IDLE is ignored.

Decomposition:
- Shared package/define file: DBITS, REGNOBITS, IOPBITS, size encodings (SZ_B/SZ_H/SZ_W), exception codes (EXC_NONE/MISALIGN/TIMEOUT), state encodings.
- One natural sub-module, lsu_lane_align: combinational store lane steering/strobes and load extraction/extension. It is unit-tested separately.

Test Plan:
- ALU op, aluout=0x1234, rd=5, wr_reg=1 -> one cycle later wb_valid=1, wb_result=0x1234, wb_wr_reg=1; the following cycle is a bubble when in_valid=0.
- LB signed, addr=0x103, ack in first request cycle, rdata=0x80FF_FF7F -> dmem_addr=0x100; wb_result=0xFFFF_FF80; total latency 2; in_ready=0 during ACCESS.
- SH addr=0x202, data=0xAAAA_BEEF, ack after 3 wait cycles -> wstrb=1100, wdata=0xBEEF_BEEF, req held 4 cycles, wb_wr_reg=0.
- LW addr=0x301 -> no dmem_req, wb_exc=1, wb_wr_reg=0, latency 1.
- LW, never ack -> after TIMEOUT=255 wait cycles, wb_exc=2, return to IDLE, next instruction accepted.
- Reset asserted during ACCESS, then ack pulses after release -> all outputs 0, ack ignored, no spurious wb_valid.
